// File: rtl/rs_station.sv
// Reservation station for ALU ops: operand wakeup from two CDBs and a single issue output register.
// Optional macro RS_AGE_ISSUE_EN selects oldest-ready issue via an age matrix (default: lowest index).
module rs_station #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned IMM_W       = 32,
    parameter int unsigned FULL_MARGIN = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       disp_valid_in,
    input  logic [INST_W-1:0]          disp_inst_in,
    input  logic [ADDR_W-1:0]          disp_npc_in,
    input  logic [IMM_W-1:0]           disp_imm_in,
    input  logic [TAG_W-1:0]           disp_tag_in,
    input  logic [XLEN-1:0]            disp_rs1_val_in,
    input  logic [XLEN-1:0]            disp_rs2_val_in,
    input  logic [TAG_W-1:0]           disp_rs1_rely_in,
    input  logic [TAG_W-1:0]           disp_rs2_rely_in,
    output logic                       full_out,
    output logic [$clog2(DEPTH):0]     count_out,
    input  logic                       cdb0_valid_in,
    input  logic [TAG_W-1:0]           cdb0_tag_in,
    input  logic [XLEN-1:0]            cdb0_val_in,
    input  logic                       cdb1_valid_in,
    input  logic [TAG_W-1:0]           cdb1_tag_in,
    input  logic [XLEN-1:0]            cdb1_val_in,
    output logic                       iss_valid_out,
    input  logic                       iss_ready_in,
    output logic [INST_W-1:0]          iss_inst_out,
    output logic [ADDR_W-1:0]          iss_npc_out,
    output logic [IMM_W-1:0]           iss_imm_out,
    output logic [XLEN-1:0]            iss_rs1_out,
    output logic [XLEN-1:0]            iss_rs2_out,
    output logic [TAG_W-1:0]           iss_tag_out
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]  r_busy;
    logic [TAG_W-1:0]  r_q1   [DEPTH];
    logic [TAG_W-1:0]  r_q2   [DEPTH];
    logic [XLEN-1:0]   r_v1   [DEPTH];
    logic [XLEN-1:0]   r_v2   [DEPTH];
    logic [INST_W-1:0] r_inst [DEPTH];
    logic [ADDR_W-1:0] r_npc  [DEPTH];
    logic [IMM_W-1:0]  r_imm  [DEPTH];
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic              r_iss_valid;
    logic [INST_W-1:0] r_iss_inst;
    logic [ADDR_W-1:0] r_iss_npc;
    logic [IMM_W-1:0]  r_iss_imm;
    logic [XLEN-1:0]   r_iss_rs1;
    logic [XLEN-1:0]   r_iss_rs2;
    logic [TAG_W-1:0]  r_iss_tag;

    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_sel;
    logic [DEPTH-1:0]  w_freed;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_load;
    logic              w_disp_go;
    logic [TAG_W-1:0]  w_nq1 [DEPTH];
    logic [TAG_W-1:0]  w_nq2 [DEPTH];
    logic [XLEN-1:0]   w_nv1 [DEPTH];
    logic [XLEN-1:0]   w_nv2 [DEPTH];
    logic [TAG_W-1:0]  w_dq1, w_dq2;
    logic [XLEN-1:0]   w_dv1, w_dv2;

`ifdef RS_AGE_ISSUE_EN
    // r_age[i][j] set means entry j was allocated before entry i
    logic [DEPTH-1:0]  r_age [DEPTH];
`endif

    // Capture a broadcast into a pending operand; cdb1 takes precedence on a double hit.
    function automatic logic [TAG_W+XLEN-1:0] capture(input logic [TAG_W-1:0] q,
                                                       input logic [XLEN-1:0]  v);
        if (q != '0 && cdb1_valid_in && cdb1_tag_in == q) return {{TAG_W{1'b0}}, cdb1_val_in};
        if (q != '0 && cdb0_valid_in && cdb0_tag_in == q) return {{TAG_W{1'b0}}, cdb0_val_in};
        return {q, v};
    endfunction

    always_comb begin
        {w_dq1, w_dv1} = capture(disp_rs1_rely_in, disp_rs1_val_in);
        {w_dq2, w_dv2} = capture(disp_rs2_rely_in, disp_rs2_val_in);
        for (int i = 0; i < DEPTH; i++) begin
            {w_nq1[i], w_nv1[i]} = capture(r_q1[i], r_v1[i]);
            {w_nq2[i], w_nv2[i]} = capture(r_q2[i], r_v2[i]);
            w_ready[i] = r_busy[i] && r_q1[i] == '0 && r_q2[i] == '0;
        end
    end

    always_comb begin
        w_sel = '0;
`ifdef RS_AGE_ISSUE_EN
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_ready[i] && ((w_ready & r_age[i]) == '0);
        end
`else
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) w_sel = DEPTH'(1) << i;
        end
`endif
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) w_sel_idx = IDX_W'(i);
        end
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign w_load    = (w_ready != '0) && (!r_iss_valid || iss_ready_in);
    assign w_freed   = w_load ? w_sel : '0;
    assign w_disp_go = disp_valid_in && (r_count != CNT_W'(DEPTH));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy      <= '0;
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_inst  <= '0;
            r_iss_npc   <= '0;
            r_iss_imm   <= '0;
            r_iss_rs1   <= '0;
            r_iss_rs2   <= '0;
            r_iss_tag   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
                r_inst[i] <= '0;
                r_npc[i]  <= '0;
                r_imm[i]  <= '0;
                r_tag[i]  <= '0;
`ifdef RS_AGE_ISSUE_EN
                r_age[i]  <= '0;
`endif
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy      <= '0;
                r_count     <= '0;
                r_iss_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_busy[i]) begin
                        r_q1[i] <= w_nq1[i];
                        r_v1[i] <= w_nv1[i];
                        r_q2[i] <= w_nq2[i];
                        r_v2[i] <= w_nv2[i];
                    end
                end

                if (w_load) begin
                    r_busy[w_sel_idx] <= 1'b0;
                    r_iss_valid       <= 1'b1;
                    r_iss_inst        <= r_inst[w_sel_idx];
                    r_iss_npc         <= r_npc[w_sel_idx];
                    r_iss_imm         <= r_imm[w_sel_idx];
                    r_iss_rs1         <= r_v1[w_sel_idx];
                    r_iss_rs2         <= r_v2[w_sel_idx];
                    r_iss_tag         <= r_tag[w_sel_idx];
                end else if (iss_ready_in) begin
                    r_iss_valid <= 1'b0;
                end

                if (w_disp_go) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_q1[w_free_idx]   <= w_dq1;
                    r_v1[w_free_idx]   <= w_dv1;
                    r_q2[w_free_idx]   <= w_dq2;
                    r_v2[w_free_idx]   <= w_dv2;
                    r_inst[w_free_idx] <= disp_inst_in;
                    r_npc[w_free_idx]  <= disp_npc_in;
                    r_imm[w_free_idx]  <= disp_imm_in;
                    r_tag[w_free_idx]  <= disp_tag_in;
`ifdef RS_AGE_ISSUE_EN
                    // New entry is the youngest: nobody may count it as older.
                    for (int k = 0; k < DEPTH; k++) r_age[k][w_free_idx] <= 1'b0;
                    r_age[w_free_idx] <= r_busy & ~w_freed;
`endif
                end

                if (w_disp_go && !w_load)      r_count <= r_count + CNT_W'(1);
                else if (!w_disp_go && w_load) r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign full_out      = (r_count >= CNT_W'(DEPTH - FULL_MARGIN));
    assign count_out     = r_count;
    assign iss_valid_out = r_iss_valid;
    assign iss_inst_out  = r_iss_inst;
    assign iss_npc_out   = r_iss_npc;
    assign iss_imm_out   = r_iss_imm;
    assign iss_rs1_out   = r_iss_rs1;
    assign iss_rs2_out   = r_iss_rs2;
    assign iss_tag_out   = r_iss_tag;

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: vector table for dispatch/resolve, plus sequences for
// wakeup, fill/back-pressure, ordering (build-dependent), rdy freeze, flush and async reset.
module tb_rs_station;
    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, disp_valid_in;
    logic [31:0] disp_inst_in, disp_npc_in, disp_imm_in;
    logic [3:0]  disp_tag_in, disp_rs1_rely_in, disp_rs2_rely_in;
    logic [31:0] disp_rs1_val_in, disp_rs2_val_in;
    logic        full_out;
    logic [4:0]  count_out;
    logic        cdb0_valid_in, cdb1_valid_in;
    logic [3:0]  cdb0_tag_in, cdb1_tag_in;
    logic [31:0] cdb0_val_in, cdb1_val_in;
    logic        iss_valid_out, iss_ready_in;
    logic [31:0] iss_inst_out, iss_npc_out, iss_imm_out, iss_rs1_out, iss_rs2_out;
    logic [3:0]  iss_tag_out;

    int n_pass = 0;
    int n_total = 0;

    rs_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid_in(disp_valid_in), .disp_inst_in(disp_inst_in), .disp_npc_in(disp_npc_in),
        .disp_imm_in(disp_imm_in), .disp_tag_in(disp_tag_in),
        .disp_rs1_val_in(disp_rs1_val_in), .disp_rs2_val_in(disp_rs2_val_in),
        .disp_rs1_rely_in(disp_rs1_rely_in), .disp_rs2_rely_in(disp_rs2_rely_in),
        .full_out(full_out), .count_out(count_out),
        .cdb0_valid_in(cdb0_valid_in), .cdb0_tag_in(cdb0_tag_in), .cdb0_val_in(cdb0_val_in),
        .cdb1_valid_in(cdb1_valid_in), .cdb1_tag_in(cdb1_tag_in), .cdb1_val_in(cdb1_val_in),
        .iss_valid_out(iss_valid_out), .iss_ready_in(iss_ready_in),
        .iss_inst_out(iss_inst_out), .iss_npc_out(iss_npc_out), .iss_imm_out(iss_imm_out),
        .iss_rs1_out(iss_rs1_out), .iss_rs2_out(iss_rs2_out), .iss_tag_out(iss_tag_out)
    );

    always #5 clk_in = ~clk_in;

    // Dispatch into a completely full station is a protocol error on the bench side.
    always @(posedge clk_in) begin
        if (rst_in && rdy_in && disp_valid_in && !flush_in && count_out == 5'(DEPTH)) begin
            n_total++;
            $display("FAIL protocol: dispatch with count=%0d", count_out);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid_in = 1'b0;
        cdb0_valid_in = 1'b0;
        cdb1_valid_in = 1'b0;
        flush_in      = 1'b0;
    endtask

    task automatic disp(input logic [3:0] tag, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [3:0] r1, input logic [3:0] r2);
        disp_valid_in    = 1'b1;
        disp_tag_in      = tag;
        disp_inst_in     = 32'h0000_0100 + 32'(tag);
        disp_npc_in      = 32'h0000_8000 + 32'(tag);
        disp_imm_in      = 32'h0000_1000 + 32'(tag);
        disp_rs1_val_in  = v1;
        disp_rs2_val_in  = v2;
        disp_rs1_rely_in = r1;
        disp_rs2_rely_in = r2;
    endtask

    task automatic cdb(input int bus, input logic [3:0] tag, input logic [31:0] val);
        if (bus == 0) begin
            cdb0_valid_in = 1'b1; cdb0_tag_in = tag; cdb0_val_in = val;
        end else begin
            cdb1_valid_in = 1'b1; cdb1_tag_in = tag; cdb1_val_in = val;
        end
    endtask

    task automatic do_flush();
        idle();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] v1, v2;
        logic [3:0]  r1, r2;
        logic        c0v;
        logic [3:0]  c0t;
        logic [31:0] c0d;
        logic        c1v;
        logic [3:0]  c1t;
        logic [31:0] c1d;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] exp_seq[DEPTH];
    logic [3:0]  first_tag, second_tag;

    initial begin
        vecs[0] = '{4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'd5, 32'd7};
        vecs[1] = '{4'd1, 32'hAAAA, 32'hBBBB, 4'd0, 4'd6, 1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 32'd0,
                    32'hAAAA, 32'h66};
        vecs[2] = '{4'd2, 32'h1, 32'h12, 4'd9, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h99,
                    32'h99, 32'h12};
        vecs[3] = '{4'd5, 32'h0, 32'h0, 4'd7, 4'd7, 1'b1, 4'd7, 32'h70, 1'b0, 4'd0, 32'd0,
                    32'h70, 32'h70};
        vecs[4] = '{4'd6, 32'h0, 32'h0, 4'd3, 4'd4, 1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44,
                    32'h33, 32'h44};
        vecs[5] = '{4'd7, 32'h0, 32'h1, 4'd8, 4'd0, 1'b1, 4'd8, 32'h80, 1'b1, 4'd8, 32'h81,
                    32'h81, 32'h1};
        vecs[6] = '{4'd15, 32'hFFFF_FFFF, 32'h0, 4'd0, 4'd0, 1'b1, 4'd0, 32'hDEAD, 1'b0, 4'd0,
                    32'd0, 32'hFFFF_FFFF, 32'h0};

        rst_in = 1'b0; rdy_in = 1'b1; iss_ready_in = 1'b1;
        idle();
        disp(4'd0, 32'd0, 32'd0, 4'd0, 4'd0);
        disp_valid_in = 1'b0;
        cdb0_tag_in = '0; cdb0_val_in = '0; cdb1_tag_in = '0; cdb1_val_in = '0;
        #1;
        chk("reset_valid", iss_valid_out, 1'b0);
        chk("reset_count", count_out, 5'd0);
        chk("reset_full", full_out, 1'b0);
        chk("reset_tag", iss_tag_out, 4'd0);
        #12 rst_in = 1'b1;
        tick();

        // Table: dispatch with same-cycle resolution, issue one cycle later.
        for (int v = 0; v < 7; v++) begin
            disp(vecs[v].tag, vecs[v].v1, vecs[v].v2, vecs[v].r1, vecs[v].r2);
            if (vecs[v].c0v) cdb(0, vecs[v].c0t, vecs[v].c0d);
            if (vecs[v].c1v) cdb(1, vecs[v].c1t, vecs[v].c1d);
            tick();
            idle();
            chk($sformatf("v%0d_cnt1", v), count_out, 5'd1);
            chk($sformatf("v%0d_novalid", v), iss_valid_out, 1'b0);
            tick();
            chk($sformatf("v%0d_valid", v), iss_valid_out, 1'b1);
            chk($sformatf("v%0d_tag", v), iss_tag_out, vecs[v].tag);
            chk($sformatf("v%0d_rs1", v), iss_rs1_out, vecs[v].e1);
            chk($sformatf("v%0d_rs2", v), iss_rs2_out, vecs[v].e2);
            chk($sformatf("v%0d_imm", v), iss_imm_out, 32'h1000 + 32'(vecs[v].tag));
            chk($sformatf("v%0d_cnt0", v), count_out, 5'd0);
            tick();
            chk($sformatf("v%0d_drain", v), iss_valid_out, 1'b0);
        end

        // Wakeup over two later broadcasts.
        disp(4'd4, 32'd0, 32'd0, 4'd2, 4'd5);
        tick(); idle();
        cdb(0, 4'd2, 32'h11);
        tick(); idle();
        chk("wk_wait", iss_valid_out, 1'b0);
        cdb(1, 4'd5, 32'h22);
        tick(); idle();
        chk("wk_not_yet", iss_valid_out, 1'b0);
        tick();
        chk("wk_valid", iss_valid_out, 1'b1);
        chk("wk_tag", iss_tag_out, 4'd4);
        chk("wk_rs1", iss_rs1_out, 32'h11);
        chk("wk_rs2", iss_rs2_out, 32'h22);
        tick();

        // Fill under back-pressure, then drain back to back.
        iss_ready_in = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'(i), 32'(100 + i), 32'(200 + i), 4'd0, 4'd0);
            tick();
            if (i == 14) begin
                chk("fill_cnt14", count_out, 5'd14);
                chk("fill_notfull", full_out, 1'b0);
            end
        end
        idle();
        chk("fill_cnt", count_out, 5'd15);
        chk("fill_full", full_out, 1'b1);
        chk("fill_head", iss_rs1_out, 32'd100);
        tick();
        chk("fill_stable", iss_rs1_out, 32'd100);
        chk("fill_hold", iss_valid_out, 1'b1);
        for (int k = 0; k < DEPTH; k++) exp_seq[k] = 32'(100 + k);
`ifndef RS_AGE_ISSUE_EN
        exp_seq[1] = 32'd102;
        exp_seq[2] = 32'd101;
`endif
        iss_ready_in = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            tick();
            chk($sformatf("drain%0d_valid", k), iss_valid_out, 1'b1);
            chk($sformatf("drain%0d_rs1", k), iss_rs1_out, exp_seq[k]);
        end
        tick();
        chk("drain_end", iss_valid_out, 1'b0);
        chk("drain_cnt", count_out, 5'd0);

        // Ordering: A in entry 5, B later in entry 0, both woken together.
        disp(4'd10, 32'd0, 32'd0, 4'd1, 4'd0); tick();
        for (int i = 0; i < 4; i++) begin
            disp(4'(11 + i), 32'd0, 32'd0, 4'd2, 4'd0); tick();
        end
        disp(4'd8, 32'd0, 32'd0, 4'd3, 4'd0); tick();
        idle();
        cdb(0, 4'd1, 32'h1); tick(); idle();
        tick();
        chk("ord_e0", iss_tag_out, 4'd10);
        tick();
        disp(4'd9, 32'd0, 32'd0, 4'd3, 4'd0); tick(); idle();
        cdb(0, 4'd3, 32'h3); tick(); idle();
`ifdef RS_AGE_ISSUE_EN
        first_tag = 4'd8; second_tag = 4'd9;
`else
        first_tag = 4'd9; second_tag = 4'd8;
`endif
        tick();
        chk("ord_first", iss_tag_out, first_tag);
        tick();
        chk("ord_second", iss_tag_out, second_tag);
        chk("ord_cnt", count_out, 5'd4);
        do_flush();
        chk("ord_flush", count_out, 5'd0);

        // rdy_in low freezes state and loses the broadcast.
        disp(4'd12, 32'd0, 32'd0, 4'd7, 4'd0); tick(); idle();
        rdy_in = 1'b0;
        cdb(0, 4'd7, 32'h7);
        disp(4'd13, 32'd0, 32'd0, 4'd0, 4'd0);
        tick(); idle();
        chk("rdy_cnt", count_out, 5'd1);
        rdy_in = 1'b1;
        tick(); tick();
        chk("rdy_lost", iss_valid_out, 1'b0);
        do_flush();

        // Flush beats a same-cycle dispatch with 6 occupied and output valid.
        iss_ready_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            disp(4'(i + 1), 32'(i), 32'd0, 4'd0, 4'd0); tick();
        end
        idle();
        chk("fl_cnt6", count_out, 5'd6);
        chk("fl_valid", iss_valid_out, 1'b1);
        disp(4'd9, 32'd0, 32'd0, 4'd0, 4'd0);
        flush_in = 1'b1;
        tick(); idle();
        chk("fl_cnt0", count_out, 5'd0);
        chk("fl_novalid", iss_valid_out, 1'b0);
        iss_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fl_quiet%0d", i), iss_valid_out, 1'b0);
        end

        // Mid-cycle asynchronous reset.
        iss_ready_in = 1'b0;
        disp(4'd6, 32'd1, 32'd2, 4'd0, 4'd0); tick(); idle(); tick();
        chk("ar_pre", iss_valid_out, 1'b1);
        #2 rst_in = 1'b0;
        #1;
        chk("ar_valid", iss_valid_out, 1'b0);
        chk("ar_count", count_out, 5'd0);
        chk("ar_full", full_out, 1'b0);
        chk("ar_tag", iss_tag_out, 4'd0);
        #1 rst_in = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
